// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring radix-2 divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Sits beside the single-cycle ALU and returns its result on the shared rd write-back triple.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_we_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             div_rd_we_o,
  output logic [4:0]       div_rd_waddr_o,
  output logic [WIDTH-1:0] div_rd_wdata_o,
  output logic             valid_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, quot_q, rem_q;
  logic             neg_q_q, neg_r_q;
  logic             rem_sel_q;
  logic [4:0]       rd_addr_q;
  logic             rd_we_q;

  // Request decode: signed ops take magnitudes, special cases skip the iteration.
  logic             signed_op, a_neg, b_neg, div_zero, sgn_ovf, accept;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign signed_op = ~div_op_i[0];
  assign a_neg     = signed_op & operand_a_i[WIDTH-1];
  assign b_neg     = signed_op & operand_b_i[WIDTH-1];
  assign abs_a     = a_neg ? -operand_a_i : operand_a_i;
  assign abs_b     = b_neg ? -operand_b_i : operand_b_i;
  assign div_zero  = (operand_b_i == '0);
  assign sgn_ovf   = signed_op && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (operand_b_i == '1);
  assign accept    = (state_q == IDLE) && start_i && !flush_i;

  // One restoring step; the extra top bit keeps the compare/subtract overflow-free.
  logic [WIDTH:0]   rem_shift, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;

  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[WIDTH];
  assign rem_step  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
    end else if (accept) begin
      rem_sel_q <= div_op_i[1];
      rd_addr_q <= rd_addr_i;
      rd_we_q   <= rd_we_i;
      if (div_zero) begin
        quot_q  <= '1;
        rem_q   <= operand_a_i;
        neg_q_q <= 1'b0;
        neg_r_q <= 1'b0;
      end else if (sgn_ovf) begin
        quot_q  <= {1'b1, {(WIDTH-1){1'b0}}};
        rem_q   <= '0;
        neg_q_q <= 1'b0;
        neg_r_q <= 1'b0;
      end else begin
        dvd_q   <= abs_a;
        dvs_q   <= abs_b;
        quot_q  <= '0;
        rem_q   <= '0;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        cnt_q   <= CW'(WIDTH - 1);
      end
    end else if (state_q == CALC) begin
      dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q  <= rem_step;
      quot_q <= {quot_q[WIDTH-2:0], q_bit};
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  logic [WIDTH-1:0] result;
  always_comb begin
    if (rem_sel_q) result = neg_r_q ? -rem_q  : rem_q;
    else           result = neg_q_q ? -quot_q : quot_q;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    ready_o        = 1'b0;
    busy_o         = 1'b0;
    valid_o        = 1'b0;
    div_rd_we_o    = 1'b0;
    div_rd_waddr_o = '0;
    div_rd_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = (div_zero || sgn_ovf) ? DONE : CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (flush_i)           state_d = IDLE;
        else if (cnt_q == '0)  state_d = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        state_d = IDLE;
        // Write-back stays all-zero when flushed so it can be OR-merged with the ALU.
        if (!flush_i) begin
          valid_o        = 1'b1;
          div_rd_we_o    = rd_we_q;
          div_rd_waddr_o = rd_addr_q;
          div_rd_wdata_o = result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: expected write-backs are queued at request time from a
// reference model built on SV arithmetic and popped when valid_o fires.
module tb_div_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  div_op_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic        flush_i;
  logic        ready_o, busy_o, div_rd_we_o, valid_o;
  logic [4:0]  div_rd_waddr_o;
  logic [31:0] div_rd_wdata_o;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .div_op_i       (div_op_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .rd_addr_i      (rd_addr_i),
    .rd_we_i        (rd_we_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .div_rd_we_o    (div_rd_we_o),
    .div_rd_waddr_o (div_rd_waddr_o),
    .div_rd_wdata_o (div_rd_wdata_o),
    .valid_o        (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  addr;
    logic        we;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t scoreboard[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics, including the divide-by-zero and overflow results.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      OP_DIV:  return sa / sb;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, b,
                          input logic [4:0] addr, input logic we);
    exp_t e;
    e.addr = addr;
    e.we   = we;
    e.data = model(op, a, b);
    e.lat  = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    scoreboard.push_back(e);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1 after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, b,
                          input logic [4:0] addr, input logic we, input bit hold);
    check("ready_before_start", ready_o, 1'b1);
    div_op_i    = op;
    operand_a_i = a;
    operand_b_i = b;
    rd_addr_i   = addr;
    rd_we_i     = we;
    start_i     = 1'b1;
    push_exp(op, a, b, addr, we);
    @(negedge clk_i);
    if (!hold) begin
      start_i     = 1'b0;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      rd_addr_i   = 5'($urandom);
    end
  endtask

  // Entered at the negedge of cycle 1 after accept; bounded wait for the result pulse.
  task automatic wait_result();
    exp_t e;
    int   cyc = 1;
    while (valid_o !== 1'b1 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    e = scoreboard.pop_front();
    check("latency", cyc, e.lat);
    check("busy_in_done", busy_o, 1'b1);
    check("wdata", div_rd_wdata_o, e.data);
    check("waddr", div_rd_waddr_o, e.addr);
    check("we", div_rd_we_o, e.we);
    @(negedge clk_i);
    check("valid_after_done", valid_o, 1'b0);
    check("ready_after_done", ready_o, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b,
                        input logic [4:0] addr, input logic we);
    start_op(op, a, b, addr, we, 1'b0);
    wait_result();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; div_op_i = '0;
    operand_a_i = '0; operand_b_i = '0; rd_addr_i = '0; rd_we_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_we", div_rd_we_o, 1'b0);
    check("rst_waddr", div_rd_waddr_o, 5'd0);
    check("rst_wdata", div_rd_wdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Normal iteration, signed fixups
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b1);
    run_op(OP_REMU, 32'd100, 32'd7, 5'd6, 1'b1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd12, 1'b1);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 1'b1);
    run_op(OP_DIV, 32'h8000_0000, 32'd3, 5'd1, 1'b1);

    // Bypass cases
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, 5'd13, 1'b1);
    run_op(OP_REM, 32'd5, 32'd0, 5'd14, 1'b1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);

    // Flush at CALC cycle 10, immediate restart on return to IDLE
    div_op_i = OP_DIVU; operand_a_i = 32'd1000; operand_b_i = 32'd3;
    rd_addr_i = 5'd7; rd_we_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    check("busy_in_calc", busy_o, 1'b1);
    check("flush_valid", valid_o, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd9, 1'b1);

    // Flush beats start in IDLE
    div_op_i = OP_DIVU; operand_a_i = 32'd8; operand_b_i = 32'd0;
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_ready", ready_o, 1'b1);
    check("flush_idle_valid", valid_o, 1'b0);

    // Asynchronous reset mid-op
    div_op_i = OP_REMU; operand_a_i = 32'd77; operand_b_i = 32'd5;
    rd_addr_i = 5'd20; rd_we_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("async_rst_ready", ready_o, 1'b1);
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_we", div_rd_we_o, 1'b0);
    check("async_rst_wdata", div_rd_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1'b1;
    end
    check("no_wb_after_reset", seen, 1'b0);
    check("ready_after_reset", ready_o, 1'b1);

    // start_i held through DONE: second op accepted only after returning to IDLE
    start_op(OP_DIVU, 32'd50, 32'd5, 5'd3, 1'b1, 1'b1);
    div_op_i = OP_DIVU; operand_a_i = 32'd20; operand_b_i = 32'd4;
    rd_addr_i = 5'd4; rd_we_i = 1'b0;
    push_exp(OP_DIVU, 32'd20, 32'd4, 5'd4, 1'b0);
    wait_result();
    @(negedge clk_i);
    start_i = 1'b0;
    wait_result();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
